iic_slave_regfile: RTL and testbench
====================================

Name: iic_slave_regfile

Overview:
I2C/SCCB target (responder) that answers the camera-style master transactions: 7-bit device address, 16-bit register address (high byte, then low byte), 8-bit data. Holds a small register file that the master can write and read. Emits a one-cycle write strobe per accepted data byte so fabric logic can mirror camera configuration. Used as a camera stand-in on the board and as the bench responder for the team's IIC master.

Parameters:
SLAVE_ADDR, 7'h36, 7-bit device address this target responds to.
DEPTH, 256, number of 8-bit registers, mapped at register addresses 0..DEPTH-1.
FILTER_LEN, 4, number of consecutive equal samples (after 2-FF sync) required to accept a new SCL/SDA level.

Ports:
i_clk  in  1  system clock (100 MHz); all logic is on this clock.
i_rst  in  1  synchronous reset, active-high.
i_iic_scl  in  1  bus SCL (input only; no clock stretching).
i_iic_sda  in  1  bus SDA as seen at the IOBUF output.
o_iic_sda  out  1  SDA drive value; always 0 (open-drain).
o_sda_dir  out  1  1 = drive SDA low; 0 = release.
o_wr_valid  out  1  one-cycle pulse when a data byte is written.
o_wr_addr  out  16  register address of that write.
o_wr_data  out  8  data byte of that write.
o_busy  out  1  1 from addressed START until STOP or NACK/release.

Behaviour:
- Reset: o_sda_dir=0, o_iic_sda=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_busy=0, pointer=0, all registers=8'h00, state=IDLE. Reset mid-transfer releases SDA within 1 cycle.
- Input path: 2-FF sync, then a filter that accepts a level after FILTER_LEN equal samples. Events (SCL rise/fall, START, STOP) are single-cycle pulses from the filtered signals.
- START = filtered SDA falls while SCL high. STOP = SDA rises while SCL high. START in any state (including repeated START) goes to DEV_ADDR and keeps the pointer. STOP in any state goes to IDLE, releases SDA and clears o_busy.
- Bits are sampled on SCL rise, MSB first. SDA is changed only on SCL fall, 1 cycle after the fall event.
- States: IDLE, DEV_ADDR, ACK_DEV, REG_H, ACK_H, REG_L, ACK_L, WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP.
- DEV_ADDR: after 8 bits, address match → ACK_DEV and o_busy=1. Mismatch → WAIT_STOP, never driving SDA.
- ACK states: SDA driven low from the SCL fall after bit 8 to the SCL fall after bit 9.
- After ACK_DEV:
  - R/W=0 → REG_H → ACK_H → REG_L → ACK_L; pointer={H,L} is loaded at the end of REG_L. Then → WR_DATA.
  - R/W=1 → RD_DATA using the current pointer.
- WR_DATA: every byte is ACKed. At the 8th SCL rise: if pointer<DEPTH, write the register. In all cases pulse o_wr_valid with o_wr_addr=pointer and o_wr_data=byte. This happens even for pointer≥DEPTH (write dropped, still ACKed and strobed).
- RD_DATA: the shift register is loaded at the SCL fall that ends ACK_DEV or RD_ACK. Value is reg[pointer], or 8'h00 if pointer≥DEPTH. A 0 bit drives o_sda_dir=1; a 1 bit releases. After 8 bits, release SDA and go to RD_ACK, sampling the master bit on the 9th SCL rise.
  - Master ACK (0) → next byte.
  - Master NACK (1) → WAIT_STOP.
- Pointer width is 16 bits and wraps from 0xFFFF to 0x0000.
- Simultaneous STOP and SCL event in the same cycle: STOP wins.

Optional Feature:
IIC_ADDR_AUTOINC_EN
- Defined: pointer increments by 1 after each written byte's ACK and after each read byte's master ACK/NACK, so burst transfers walk the address space.
- Undefined: pointer stays fixed; a burst write overwrites one register and a burst read repeats the same byte.

Test Plan:
- Write 0x36/W, 0x00, 0x12, 0xA5, STOP → ACK on all 4 bytes; o_wr_valid pulses once with addr 0x0012 and data 0xA5; o_busy falls after STOP.
- Set pointer 0x0012, repeated START, 0x36/R, master NACK → byte 0xA5 on SDA; SDA released at the 9th clock; WAIT_STOP, then IDLE.
- Address 0x3C/W → no ACK (SDA never driven); o_busy stays 0; no o_wr_valid.
- Write 0x30, 0x08, 0x42 → ACKed and strobed with addr 0x3008; read of 0x3008 returns 0x00.
- With IIC_ADDR_AUTOINC_EN: write 0x0010 ← 0x11, 0x22, 0x33; read 3 bytes from 0x0010 → 0x11, 0x22, 0x33. Without the macro: the register reads 0x33 and the burst read returns 0x33 ×3.
- Assert i_rst during the ACK of the register-low byte → SDA released next cycle; registers read 0x00 afterwards; a new transaction works normally.

Source files
------------

// File: rtl/iic_slave_regfile_if.sv
// Bus bundle for iic_slave_regfile: I2C/SCCB pins plus the register-write strobe.
//   i_iic_scl  : bus SCL level (input only, no clock stretching)
//   i_iic_sda  : bus SDA level as seen at the IOBUF output
//   o_iic_sda  : SDA drive value, constant 0 (open-drain)
//   o_sda_dir  : 1 = pull SDA low, 0 = release
//   o_wr_valid : one-cycle pulse per written data byte
//   o_wr_addr  : register address of that write
//   o_wr_data  : data byte of that write
//   o_busy     : target is addressed and engaged in a transfer
interface iic_slave_regfile_if;
  logic        i_iic_scl;
  logic        i_iic_sda;
  logic        o_iic_sda;
  logic        o_sda_dir;
  logic        o_wr_valid;
  logic [15:0] o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        o_busy;

  modport slave (
    input  i_iic_scl, i_iic_sda,
    output o_iic_sda, o_sda_dir, o_wr_valid, o_wr_addr, o_wr_data, o_busy
  );

  modport master (
    output i_iic_scl, i_iic_sda,
    input  o_iic_sda, o_sda_dir, o_wr_valid, o_wr_addr, o_wr_data, o_busy
  );
endinterface

// File: rtl/iic_slave_regfile.sv
// I2C/SCCB target with a small register file: 7-bit device address,
// 16-bit register address (high then low byte), 8-bit data.
// Ports: i_clk (system clock), i_rst (synchronous, active-high),
//        bus (iic_slave_regfile_if.slave: SCL/SDA pins, write strobe, busy).
// Optional feature: define IIC_ADDR_AUTOINC_EN to auto-increment the register
// pointer after each written byte's ACK and after each read byte's master ACK/NACK.
module iic_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h36,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned FILTER_LEN = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  iic_slave_regfile_if.slave  bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, REG_H, ACK_H, REG_L, ACK_L,
    WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  // Index 0 = SCL, index 1 = SDA
  logic [1:0]    sync1, sync2, filt, filt_q;
  logic [FW-1:0] fcnt [2];

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  reg_h, reg_h_n;
  logic [15:0] ptr, ptr_n;
  logic        rw, rw_n;
  logic        phase, phase_n;
  logic        sda_dir, sda_dir_n;
  logic        busy, busy_n;
  logic        wr_valid, wr_valid_n;
  logic [15:0] wr_addr, wr_addr_n;
  logic [7:0]  wr_data, wr_data_n;
  logic        reg_we;
  logic [7:0]  regs [DEPTH];

  logic       scl_rise, scl_fall, start, stop, in_range;
  logic [7:0] rx_byte, rd_byte;

  // 2-FF synchroniser followed by a run-length glitch filter per line
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_q  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= {bus.i_iic_sda, bus.i_iic_scl};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  // Single-cycle bus events from the filtered levels
  assign scl_rise = filt[0] & ~filt_q[0];
  assign scl_fall = ~filt[0] & filt_q[0];
  assign start    = filt[0] & filt_q[0] & filt_q[1] & ~filt[1];
  assign stop     = filt[0] & filt_q[0] & ~filt_q[1] & filt[1];

  assign rx_byte  = {shreg[6:0], filt[1]};
  assign in_range = {1'b0, ptr} < 17'(DEPTH);
  assign rd_byte  = in_range ? regs[ptr[AW-1:0]] : 8'h00;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      reg_h    <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      phase    <= 1'b0;
      sda_dir  <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      reg_h    <= reg_h_n;
      ptr      <= ptr_n;
      rw       <= rw_n;
      phase    <= phase_n;
      sda_dir  <= sda_dir_n;
      busy     <= busy_n;
      wr_valid <= wr_valid_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      if (reg_we) regs[ptr[AW-1:0]] <= rx_byte;
    end
  end

  // Next-state and output logic; STOP has priority over everything, then START
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    reg_h_n    = reg_h;
    ptr_n      = ptr;
    rw_n       = rw;
    phase_n    = phase;
    sda_dir_n  = sda_dir;
    busy_n     = busy;
    wr_valid_n = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    reg_we     = 1'b0;

    if (stop) begin
      state_n   = IDLE;
      sda_dir_n = 1'b0;
      busy_n    = 1'b0;
    end else if (start) begin
      state_n   = DEV_ADDR;
      bit_cnt_n = '0;
      phase_n   = 1'b0;
      sda_dir_n = 1'b0;
    end else begin
      case (state)
        IDLE, WAIT_STOP: ;

        // Receive shift: 8 bits sampled on SCL rise, MSB first
        DEV_ADDR, REG_H, REG_L, WR_DATA: begin
          if (scl_rise) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              phase_n   = 1'b0;
              case (state)
                DEV_ADDR: begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    state_n = ACK_DEV;
                    busy_n  = 1'b1;
                    rw_n    = rx_byte[0];
                  end else begin
                    state_n = WAIT_STOP;
                    busy_n  = 1'b0;
                  end
                end
                REG_H: begin
                  reg_h_n = rx_byte;
                  state_n = ACK_H;
                end
                REG_L: begin
                  ptr_n   = {reg_h, rx_byte};
                  state_n = ACK_L;
                end
                default: begin
                  reg_we     = in_range;
                  wr_valid_n = 1'b1;
                  wr_addr_n  = ptr;
                  wr_data_n  = rx_byte;
                  state_n    = ACK_WR;
                end
              endcase
            end
          end
        end

        // Drive low on the fall after bit 8, release on the fall after bit 9
        ACK_DEV, ACK_H, ACK_L, ACK_WR: begin
          if (scl_rise) begin
            phase_n = 1'b1;
          end else if (scl_fall) begin
            if (!phase) begin
              sda_dir_n = 1'b1;
            end else begin
              sda_dir_n = 1'b0;
              phase_n   = 1'b0;
              bit_cnt_n = '0;
              case (state)
                ACK_DEV: begin
                  if (rw) begin
                    state_n   = RD_DATA;
                    shreg_n   = rd_byte;
                    sda_dir_n = ~rd_byte[7];
                  end else begin
                    state_n = REG_H;
                  end
                end
                ACK_H:   state_n = REG_L;
                ACK_L:   state_n = WR_DATA;
                default: begin
                  state_n = WR_DATA;
`ifdef IIC_ADDR_AUTOINC_EN
                  ptr_n = ptr + 16'd1;
`endif
                end
              endcase
            end
          end
        end

        // Transmit: MSB already on the bus, next bit presented on each fall
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_dir_n = 1'b0;
              state_n   = RD_ACK;
              phase_n   = 1'b0;
              bit_cnt_n = '0;
            end else begin
              shreg_n   = {shreg[6:0], 1'b0};
              sda_dir_n = ~shreg[6];
            end
          end
        end

        // Master ACK/NACK sampled on the 9th rise; reload on the following fall
        RD_ACK: begin
          if (scl_rise) begin
`ifdef IIC_ADDR_AUTOINC_EN
            ptr_n = ptr + 16'd1;
`endif
            if (filt[1]) begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end else begin
              phase_n = 1'b1;
            end
          end else if (scl_fall && phase) begin
            state_n   = RD_DATA;
            shreg_n   = rd_byte;
            sda_dir_n = ~rd_byte[7];
            phase_n   = 1'b0;
            bit_cnt_n = '0;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.o_iic_sda  = 1'b0;
  assign bus.o_sda_dir  = sda_dir;
  assign bus.o_wr_valid = wr_valid;
  assign bus.o_wr_addr  = wr_addr;
  assign bus.o_wr_data  = wr_data;
  assign bus.o_busy     = busy;
endmodule

// File: tb/tb_iic_slave_regfile.sv
// Directed bench for iic_slave_regfile: drives an I2C master on SCL/SDA
// (wired-AND bus with the target's pull-down) and checks ACKs, read data,
// write strobes, busy and reset behaviour. Optional macro IIC_ADDR_AUTOINC_EN
// selects the matching burst expectations.
module tb_iic_slave_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  int          wr_cnt  = 0;
  int          drv_cnt = 0;
  logic [15:0] wr_addr_q = '0;
  logic [7:0]  wr_data_q = '0;

  iic_slave_regfile_if bus ();

  assign bus.i_iic_scl = m_scl;
  assign bus.i_iic_sda = m_sda & ~bus.o_sda_dir;

  iic_slave_regfile dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Strobe and pull-down activity monitor
  always @(posedge clk) begin
    if (bus.o_wr_valid) begin
      wr_cnt    <= wr_cnt + 1;
      wr_addr_q <= bus.o_wr_addr;
      wr_data_q <= bus.o_wr_data;
    end
    if (bus.o_sda_dir) drv_cnt <= drv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period (40 clocks): SDA set mid-low, bus sampled mid-high
  task automatic xfer_bit(input logic b, output logic s);
    wait_cyc(10); m_sda = b;
    wait_cyc(10); m_scl = 1'b1;
    wait_cyc(10); s = bus.i_iic_sda;
    wait_cyc(10); m_scl = 1'b0;
  endtask

  task automatic start_cond();
    m_sda = 1'b1; wait_cyc(10);
    m_scl = 1'b1; wait_cyc(20);
    m_sda = 1'b0; wait_cyc(20);
    m_scl = 1'b0;
  endtask

  task automatic stop_cond();
    wait_cyc(10); m_sda = 1'b0;
    wait_cyc(10); m_scl = 1'b1;
    wait_cyc(20); m_sda = 1'b1;
    wait_cyc(20);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
    xfer_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output logic ninth);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, s);
      d[i] = s;
    end
    xfer_bit(nack, ninth);
  endtask

  // Write one byte with pointer setup, checking ACKs along the way
  task automatic reg_write(input string tag, input logic [15:0] a, input logic [7:0] d);
    logic ack;
    start_cond();
    write_byte(8'h6C, ack);   check({tag, "_ack_dev"}, 32'(ack), 32'd1);
    write_byte(a[15:8], ack); check({tag, "_ack_h"},   32'(ack), 32'd1);
    write_byte(a[7:0], ack);  check({tag, "_ack_l"},   32'(ack), 32'd1);
    write_byte(d, ack);       check({tag, "_ack_wr"},  32'(ack), 32'd1);
    stop_cond();
  endtask

  // Set pointer, repeated START, read one byte with NACK
  task automatic reg_read(input logic [15:0] a, output logic [7:0] d, output logic ninth);
    logic ack;
    start_cond();
    write_byte(8'h6C, ack);
    write_byte(a[15:8], ack);
    write_byte(a[7:0], ack);
    start_cond();
    write_byte(8'h6D, ack);
    read_byte(1'b1, d, ninth);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        ack, ninth;
    logic [7:0]  d;
    int          wr0, drv0;

    // Reset state
    wait_cyc(5);
    check("rst_sda_dir",  32'(bus.o_sda_dir),  32'd0);
    check("rst_iic_sda",  32'(bus.o_iic_sda),  32'd0);
    check("rst_busy",     32'(bus.o_busy),     32'd0);
    check("rst_wr_valid", 32'(bus.o_wr_valid), 32'd0);
    check("rst_wr_addr",  32'(bus.o_wr_addr),  32'd0);
    check("rst_wr_data",  32'(bus.o_wr_data),  32'd0);
    rst = 1'b0;
    wait_cyc(20);

    // Basic write 0x0012 <= 0xA5
    wr0 = wr_cnt;
    start_cond();
    write_byte(8'h6C, ack); check("w1_ack_dev", 32'(ack), 32'd1);
    write_byte(8'h00, ack); check("w1_ack_h",   32'(ack), 32'd1);
    write_byte(8'h12, ack); check("w1_ack_l",   32'(ack), 32'd1);
    write_byte(8'hA5, ack); check("w1_ack_wr",  32'(ack), 32'd1);
    check("w1_busy_hi", 32'(bus.o_busy), 32'd1);
    stop_cond();
    check("w1_busy_lo",  32'(bus.o_busy), 32'd0);
    check("w1_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("w1_wr_addr",  32'(wr_addr_q), 32'h0012);
    check("w1_wr_data",  32'(wr_data_q), 32'hA5);

    // Read back with repeated START and NACK
    wr0 = wr_cnt;
    reg_read(16'h0012, d, ninth);
    check("r1_data",     32'(d), 32'hA5);
    check("r1_release",  32'(ninth), 32'd1);
    check("r1_busy_lo",  32'(bus.o_busy), 32'd0);
    check("r1_sda_dir",  32'(bus.o_sda_dir), 32'd0);
    stop_cond();
    check("r1_no_write", 32'(wr_cnt - wr0), 32'd0);

    // Wrong device address: never ACKed, never driven
    wr0 = wr_cnt; drv0 = drv_cnt;
    start_cond();
    write_byte(8'h78, ack); check("na_ack",  32'(ack), 32'd0);
    check("na_busy", 32'(bus.o_busy), 32'd0);
    write_byte(8'h00, ack); check("na_ack2", 32'(ack), 32'd0);
    stop_cond();
    check("na_drive",    32'(drv_cnt - drv0), 32'd0);
    check("na_no_write", 32'(wr_cnt - wr0), 32'd0);

    // Out-of-range write: ACKed and strobed but not stored
    wr0 = wr_cnt;
    reg_write("oor", 16'h3008, 8'h42);
    check("oor_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("oor_wr_addr",  32'(wr_addr_q), 32'h3008);
    check("oor_wr_data",  32'(wr_data_q), 32'h42);
    reg_read(16'h3008, d, ninth);
    stop_cond();
    check("oor_rd", 32'(d), 32'h00);

    // Burst write 0x0010 <= 11,22,33
    wr0 = wr_cnt;
    start_cond();
    write_byte(8'h6C, ack);
    write_byte(8'h00, ack);
    write_byte(8'h10, ack);
    write_byte(8'h11, ack); check("bw_ack1", 32'(ack), 32'd1);
    write_byte(8'h22, ack); check("bw_ack2", 32'(ack), 32'd1);
    write_byte(8'h33, ack); check("bw_ack3", 32'(ack), 32'd1);
    stop_cond();
    check("bw_wr_count", 32'(wr_cnt - wr0), 32'd3);
`ifdef IIC_ADDR_AUTOINC_EN
    check("bw_last_addr", 32'(wr_addr_q), 32'h0012);
`else
    check("bw_last_addr", 32'(wr_addr_q), 32'h0010);
`endif

    // Burst read 3 bytes from 0x0010
    start_cond();
    write_byte(8'h6C, ack);
    write_byte(8'h00, ack);
    write_byte(8'h10, ack);
    start_cond();
    write_byte(8'h6D, ack); check("br_ack_dev", 32'(ack), 32'd1);
`ifdef IIC_ADDR_AUTOINC_EN
    read_byte(1'b0, d, ninth); check("br_d0", 32'(d), 32'h11);
    read_byte(1'b0, d, ninth); check("br_d1", 32'(d), 32'h22);
    read_byte(1'b1, d, ninth); check("br_d2", 32'(d), 32'h33);
`else
    read_byte(1'b0, d, ninth); check("br_d0", 32'(d), 32'h33);
    read_byte(1'b0, d, ninth); check("br_d1", 32'(d), 32'h33);
    read_byte(1'b1, d, ninth); check("br_d2", 32'(d), 32'h33);
`endif
    check("br_busy_lo", 32'(bus.o_busy), 32'd0);
    stop_cond();

    // Reset asserted while the target ACKs the register-low byte
    start_cond();
    write_byte(8'h6C, ack);
    write_byte(8'h00, ack);
    for (int i = 7; i >= 0; i--) begin
      logic s;
      xfer_bit(1'b0, s);
    end
    wait_cyc(10); m_sda = 1'b1;
    check("rs_acking", 32'(bus.o_sda_dir), 32'd1);
    rst = 1'b1;
    wait_cyc(1);
    check("rs_released", 32'(bus.o_sda_dir), 32'd0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(10); m_scl = 1'b1;
    wait_cyc(20); m_scl = 1'b0;
    stop_cond();
    check("rs_busy", 32'(bus.o_busy), 32'd0);
    reg_read(16'h0010, d, ninth);
    stop_cond();
    check("rs_rd_0010", 32'(d), 32'h00);
    reg_read(16'h0012, d, ninth);
    stop_cond();
    check("rs_rd_0012", 32'(d), 32'h00);

    // Fresh transaction after reset
    wr0 = wr_cnt;
    reg_write("post", 16'h0005, 8'h5A);
    check("post_wr_addr", 32'(wr_addr_q), 32'h0005);
    check("post_wr_data", 32'(wr_data_q), 32'h5A);
    check("post_wr_count", 32'(wr_cnt - wr0), 32'd1);
    reg_read(16'h0005, d, ninth);
    stop_cond();
    check("post_rd", 32'(d), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
